ctrl_queue_arbiter: RTL and testbench



---
 rtl/ctrl_queue_arbiter_pkg.sv | 14 +
 rtl/ctrl_queue_fifo.sv | 61 ++++++
 rtl/ctrl_queue_arbiter.sv | 154 +++++++++++++++
 tb/tb_ctrl_queue_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_queue_arbiter_pkg.sv
// Shared definitions for the queued load arbiter: FSM state encodings and
// the simultaneous-request pick modes.
package ctrl_queue_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int RR_FIXED = 0;
   localparam int RR_ROBIN = 1;

endpackage

// File: rtl/ctrl_queue_fifo.sv
// Arrival-order queue of channel indices. Pointers wrap naturally; the
// occupancy counter is one bit wider so that full and empty are distinct.
module ctrl_queue_fifo
   import ctrl_queue_arbiter_pkg::*;
#(
   parameter int N_CH  = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [$clog2(N_CH)-1:0]    push_data,
   input  logic                       pop,
   output logic [$clog2(N_CH)-1:0]    head,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       empty,
   output logic                       full
);

   localparam int CW = $clog2(N_CH);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [CW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_reg;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign level = level_reg;
   assign empty = (level_reg == '0);
   assign full  = (level_reg == LW'(DEPTH));

endmodule

// File: rtl/ctrl_queue_arbiter.sv
// Queued load arbiter: picks one eligible requester per edge into a FIFO and
// grants the head through a one-hot enable until its BUSY falls or it times out.
module ctrl_queue_arbiter
   import ctrl_queue_arbiter_pkg::*;
#(
   parameter int N_CH     = 8,
   parameter int DEPTH    = 8,
   parameter int RR_MODE  = 0,
   parameter int START_TO = 0
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [N_CH-1:0]          REQUEST,
   input  logic [N_CH-1:0]          BUSY,
   output logic [N_CH-1:0]          EN,
   output logic [N_CH-1:0]          REQUEST_OK,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic                     EMPTY,
   output logic                     FULL,
   output logic                     TIMEOUT_ERR
);

   localparam int CW = $clog2(N_CH);
   localparam int TW = $clog2(START_TO + 2);
   localparam logic [TW-1:0] TO_LAST = (START_TO > 0) ? TW'(START_TO - 1) : '0;

   state_t          state_reg, state_next;
   logic [N_CH-1:0] en_reg, en_next;
   logic [N_CH-1:0] ok_reg, ok_next;
   logic            err_reg, err_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic [CW-1:0]   rr_ptr_reg, rr_next;

   logic [N_CH-1:0] eligible;
   logic            pick_valid;
   logic [CW-1:0]   pick_idx;
   logic            push, pop, release_now;
   logic [CW-1:0]   head;
   logic            empty, full;
   int              base, cand;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_elig
         assign eligible[gi] = REQUEST[gi] & ~ok_reg[gi];
      end
   endgenerate

   // Scan downward so the candidate closest to the search base wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      base       = (RR_MODE == RR_ROBIN) ? int'(rr_ptr_reg) : 0;
      for (int o = N_CH - 1; o >= 0; o--) begin
         cand = (base + o) % N_CH;
         if (eligible[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = CW'(cand);
         end
      end
   end

   assign push    = pick_valid & ~full;
   assign rr_next = (pick_idx == CW'(N_CH - 1)) ? '0 : pick_idx + 1'b1;

   always_comb begin
      state_next  = state_reg;
      en_next     = en_reg;
      timer_next  = timer_reg;
      err_next    = 1'b0;
      release_now = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            timer_next = '0;
            if (!empty) begin
               state_next = ST_GRANT;
               en_next    = {{(N_CH-1){1'b0}}, 1'b1} << head;
            end
         end
         ST_GRANT: begin
            if (BUSY[head]) begin
               state_next = ST_RUN;
            end else if (START_TO != 0) begin
               timer_next = timer_reg + 1'b1;
               if (timer_reg == TO_LAST) begin
                  release_now = 1'b1;
                  err_next    = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!BUSY[head]) begin
               release_now = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (release_now) begin
         state_next = ST_IDLE;
         en_next    = '0;
      end
      pop     = release_now;
      ok_next = ok_reg;
      if (release_now) begin
         ok_next[head] = 1'b0;
      end
      if (push) begin
         ok_next[pick_idx] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_reg  <= ST_IDLE;
         en_reg     <= '0;
         ok_reg     <= '0;
         err_reg    <= 1'b0;
         timer_reg  <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg <= state_next;
         en_reg    <= en_next;
         ok_reg    <= ok_next;
         err_reg   <= err_next;
         timer_reg <= timer_next;
         if (push) begin
            rr_ptr_reg <= rr_next;
         end
      end
   end

   ctrl_queue_fifo #(
      .N_CH  (N_CH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET),
      .push      (push),
      .push_data (pick_idx),
      .pop       (pop),
      .head      (head),
      .level     (LEVEL),
      .empty     (empty),
      .full      (full)
   );

   assign EMPTY       = empty;
   assign FULL        = full;
   assign EN          = en_reg;
   assign REQUEST_OK  = ok_reg;
   assign TIMEOUT_ERR = err_reg;

endmodule

// File: tb/tb_ctrl_queue_arbiter.sv
// Scoreboard bench: two arbiters (fixed priority with a 4-cycle start timeout,
// round-robin without timeout) share REQUEST and are checked against a queue model.
module tb_ctrl_queue_arbiter;

   localparam int N     = 8;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int TO_A  = 4;

   typedef struct packed {
      logic [N-1:0]  en;
      logic [N-1:0]  ok;
      logic [LW-1:0] level;
      logic          empty;
      logic          full;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  request, busy_a, busy_b;
   logic [N-1:0]  en_a, ok_a, en_b, ok_b;
   logic [LW-1:0] level_a, level_b;
   logic          empty_a, full_a, err_a, empty_b, full_b, err_b;

   int checks   = 0;
   int failures = 0;
   int cycle_no = 0;

   exp_t exp_a[$];
   exp_t exp_b[$];

   // Reference model state, per arbiter (0 = fixed/timeout, 1 = round-robin)
   int       mq[2][DEPTH];
   int       mcnt[2];
   bit [N-1:0] mok[2];
   bit [N-1:0] men[2];
   bit       merr[2];
   int       mphase[2];   // 0 idle, 1 granted waiting for busy, 2 running
   int       mwait[2];
   int       mrr[2];

   always #5 clk = ~clk;

   ctrl_queue_arbiter #(.N_CH(N), .DEPTH(DEPTH), .RR_MODE(0), .START_TO(TO_A)) dut_a (
      .CLK(clk), .RESET(rst_n), .REQUEST(request), .BUSY(busy_a),
      .EN(en_a), .REQUEST_OK(ok_a), .LEVEL(level_a), .EMPTY(empty_a),
      .FULL(full_a), .TIMEOUT_ERR(err_a)
   );

   ctrl_queue_arbiter #(.N_CH(N), .DEPTH(DEPTH), .RR_MODE(1), .START_TO(0)) dut_b (
      .CLK(clk), .RESET(rst_n), .REQUEST(request), .BUSY(busy_b),
      .EN(en_b), .REQUEST_OK(ok_b), .LEVEL(level_b), .EMPTY(empty_b),
      .FULL(full_b), .TIMEOUT_ERR(err_b)
   );

   task automatic model_step(input int m, input bit rstn, input bit [N-1:0] req, input bit [N-1:0] bsy);
      int rr_mode, start_to, head, pick, c;
      bit rel, to;
      bit [N-1:0] elig;
      rr_mode  = (m == 0) ? 0 : 1;
      start_to = (m == 0) ? TO_A : 0;
      if (!rstn) begin
         mcnt[m] = 0; mok[m] = '0; men[m] = '0; merr[m] = 1'b0;
         mphase[m] = 0; mwait[m] = 0; mrr[m] = 0;
         return;
      end
      head = mq[m][0];
      rel = 1'b0;
      to = 1'b0;
      merr[m] = 1'b0;
      elig = req & ~mok[m];
      pick = -1;
      if (mcnt[m] < DEPTH) begin
         for (int o = 0; o < N; o++) begin
            c = ((rr_mode != 0 ? mrr[m] : 0) + o) % N;
            if (pick < 0 && elig[c]) pick = c;
         end
      end
      case (mphase[m])
         0: if (mcnt[m] > 0) begin
               mphase[m] = 1; men[m] = '0; men[m][head] = 1'b1; mwait[m] = 0;
            end
         1: if (bsy[head]) mphase[m] = 2;
            else begin
               mwait[m]++;
               if (start_to != 0 && mwait[m] == start_to) begin rel = 1'b1; to = 1'b1; end
            end
         default: if (!bsy[head]) rel = 1'b1;
      endcase
      if (rel) begin
         for (int i = 0; i < DEPTH - 1; i++) mq[m][i] = mq[m][i+1];
         mcnt[m]--;
         men[m] = '0;
         mok[m][head] = 1'b0;
         mphase[m] = 0;
         merr[m] = to;
      end
      if (pick >= 0) begin
         mq[m][mcnt[m]] = pick;
         mcnt[m]++;
         mok[m][pick] = 1'b1;
         mrr[m] = (pick + 1) % N;
      end
   endtask

   function automatic exp_t snap(input int m);
      exp_t e;
      e.en    = men[m];
      e.ok    = mok[m];
      e.level = LW'(mcnt[m]);
      e.empty = (mcnt[m] == 0);
      e.full  = (mcnt[m] == DEPTH);
      e.err   = merr[m];
      return e;
   endfunction

   task automatic cyc(input bit rstn, input logic [N-1:0] r, input logic [N-1:0] ba, input logic [N-1:0] bb);
      rst_n   = rstn;
      request = r;
      busy_a  = ba;
      busy_b  = bb;
      @(posedge clk);
      model_step(0, rstn, r, ba);
      model_step(1, rstn, r, bb);
      exp_a.push_back(snap(0));
      exp_b.push_back(snap(1));
      cycle_no++;
      #1;
   endtask

   // Serve queued channels with a busy pattern until both models are idle and empty.
   task automatic drain();
      int k;
      k = 0;
      while ((mcnt[0] != 0 || mcnt[1] != 0 || mphase[0] != 0 || mphase[1] != 0) && k < 300) begin
         if (k % 3 == 2) cyc(1'b1, '0, '0, '0);
         else            cyc(1'b1, '0, '1, '1);
         k++;
      end
      checks++;
      if (k >= 300) begin
         failures++;
         $display("FAIL drain_bound: queues still busy after %0d cycles, required idle", k);
      end
   endtask

   task automatic chk(input string nm, input int m, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s dut%0d cycle %0d: got %0h required %0h", nm, m, cycle_no, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            chk("en",    0, 32'(en_a),    32'(e.en));
            chk("ok",    0, 32'(ok_a),    32'(e.ok));
            chk("level", 0, 32'(level_a), 32'(e.level));
            chk("empty", 0, 32'(empty_a), 32'(e.empty));
            chk("full",  0, 32'(full_a),  32'(e.full));
            chk("err",   0, 32'(err_a),   32'(e.err));
         end
         if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk("en",    1, 32'(en_b),    32'(e.en));
            chk("ok",    1, 32'(ok_b),    32'(e.ok));
            chk("level", 1, 32'(level_b), 32'(e.level));
            chk("empty", 1, 32'(empty_b), 32'(e.empty));
            chk("full",  1, 32'(full_b),  32'(e.full));
            chk("err",   1, 32'(err_b),   32'(e.err));
         end
      end
   end

   initial begin : stimulus
      logic [N-1:0] r, ba, bb;
      bit rs;
      rst_n = 1'b0; request = '0; busy_a = '0; busy_b = '0;
      repeat (3) cyc(1'b0, '0, '0, '0);

      // single one-cycle request, busy held for five cycles
      cyc(1'b1, 8'h04, '0, '0);
      cyc(1'b1, '0, '0, '0);
      repeat (5) cyc(1'b1, '0, 8'h04, 8'h04);
      repeat (3) cyc(1'b1, '0, '0, '0);

      // two simultaneous held requests
      repeat (2) cyc(1'b1, 8'h0A, '0, '0);
      drain();

      // all channels requesting
      repeat (8) cyc(1'b1, 8'hFF, '0, '0);
      repeat (3) cyc(1'b1, 8'hFF, '1, '1);
      drain();
      cyc(1'b1, 8'h81, '0, '0);
      drain();

      // start timeout on channel 5 with channel 6 queued behind it
      cyc(1'b1, 8'h60, '0, '0);
      repeat (12) cyc(1'b1, '0, '0, '0);
      drain();

      // fill to full, release with requests still held, then reset mid-run
      repeat (10) cyc(1'b1, 8'hFF, '1, '1);
      repeat (2) cyc(1'b1, 8'hFF, '0, '0);
      repeat (3) cyc(1'b1, 8'hFF, '1, '1);
      cyc(1'b0, 8'hFF, '1, '1);
      repeat (2) cyc(1'b1, '0, '0, '0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         r  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         ba = N'($urandom);
         bb = N'($urandom);
         rs = ($urandom_range(0, 199) != 0);
         cyc(rs, r, ba, bb);
      end
      drain();

      @(negedge clk);
      #1;
      checks++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
